// File: rtl/sync_fifo_pkg.sv
// Shared widths and reset values for the synchronous FIFO.
package sync_fifo_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam logic RST_WR_READY     = 1'b1;
  localparam logic RST_RD_VALID     = 1'b0;
  localparam logic RST_ALMOST_FULL  = 1'b0;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_OVERFLOW     = 1'b0;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; slave is the FIFO side.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  import sync_fifo_pkg::*;

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic                  flush_i;
  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;
  logic                  rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_ready_i;
  logic [CNT_W-1:0]      count_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_o;

  modport master (
    output flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, count_o,
           almost_full_o, almost_empty_o, overflow_o
  );

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o, count_o,
           almost_full_o, almost_empty_o, overflow_o
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered status flags and flush.
// Define SYNC_FIFO_OUT_REG_EN to add a prefetch output register (capacity DEPTH+1).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input logic       clk_i,
  input logic       rst_i,
  sync_fifo_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEPTH);
`ifdef SYNC_FIFO_OUT_REG_EN
  localparam int unsigned CAPACITY = DEPTH + 1;
`else
  localparam int unsigned CAPACITY = DEPTH;
`endif

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  af_q, af_d, ae_q, ae_d, ovf_q, ovf_d;
  logic                  wr_acc_c, rd_acc_c, pop_c;
  logic [DATA_WIDTH-1:0] ram_rd_data;
`ifdef SYNC_FIFO_OUT_REG_EN
  logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
  logic [DATA_WIDTH-1:0] ob_data_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data_i),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Next-state: transfers, occupancy and flags; flush overrides both ports.
  always_comb begin
    wr_acc_c = bus.wr_valid_i & wr_ready_q & ~bus.flush_i;
    rd_acc_c = rd_valid_q & bus.rd_ready_i & ~bus.flush_i;

    count_d = count_q;
    if (wr_acc_c & ~rd_acc_c)      count_d = count_q + CNT_W'(1);
    else if (~wr_acc_c & rd_acc_c) count_d = count_q - CNT_W'(1);
    if (bus.flush_i)               count_d = '0;

`ifdef SYNC_FIFO_OUT_REG_EN
    // Refill the output register whenever it is empty or being drained.
    pop_c = (~rd_valid_q | rd_acc_c) & (mem_cnt_q != '0) & ~bus.flush_i;
    mem_cnt_d = mem_cnt_q;
    if (wr_acc_c & ~pop_c)      mem_cnt_d = mem_cnt_q + CNT_W'(1);
    else if (~wr_acc_c & pop_c) mem_cnt_d = mem_cnt_q - CNT_W'(1);
    if (bus.flush_i)            mem_cnt_d = '0;
    rd_valid_d = ~bus.flush_i & (pop_c | (rd_valid_q & ~rd_acc_c));
`else
    pop_c      = rd_acc_c;
    rd_valid_d = (count_d != '0);
`endif

    wr_ptr_d = wr_acc_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_c    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    wr_ready_d = (count_d != CNT_W'(CAPACITY));
    af_d       = (count_d >= CNT_W'(AF_LEVEL));
    ae_d       = (count_d <= CNT_W'(AE_LEVEL));
    ovf_d      = bus.wr_valid_i & ~wr_ready_q & ~bus.flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= RST_WR_READY;
      rd_valid_q <= RST_RD_VALID;
      af_q       <= RST_ALMOST_FULL;
      ae_q       <= RST_ALMOST_EMPTY;
      ovf_q      <= RST_OVERFLOW;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SYNC_FIFO_OUT_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_cnt_q <= '0;
      ob_data_q <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (pop_c) ob_data_q <= ram_rd_data;
    end
  end

  assign bus.rd_data_o = ob_data_q;
`else
  assign bus.rd_data_o = ram_rd_data;
`endif

  assign bus.wr_ready_o     = wr_ready_q;
  assign bus.rd_valid_o     = rd_valid_q;
  assign bus.count_o        = count_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.overflow_o     = ovf_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per entry.
REQ-002 Parameter DEPTH, default 8: storage entries, any integer >= 2, not restricted to powers of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full_o threshold in entries.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty_o threshold in entries.
REQ-005 Derived CNT_W = $clog2(DEPTH+2); PTR_W = $clog2(DEPTH).
REQ-006 Port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 Port flush_i, input, 1: synchronous clear of all queued data.
REQ-009 Port wr_valid_i, input, 1: write request.
REQ-010 Port wr_data_i, input, DATA_WIDTH: write data.
REQ-011 Port wr_ready_o, output, 1: FIFO can accept a write.
REQ-012 Port rd_valid_o, output, 1: rd_data_o holds the oldest entry.
REQ-013 Port rd_data_o, output, DATA_WIDTH: head-of-queue data.
REQ-014 Port rd_ready_i, input, 1: consumer accepts the head entry.
REQ-015 Port count_o, output, CNT_W: number of held entries.
REQ-016 Port almost_full_o / almost_empty_o, output, 1 each: threshold flags.
REQ-017 Port overflow_o, output, 1: one-cycle pulse on a refused write.

Function
REQ-018 A write is accepted on an edge where wr_valid_i and wr_ready_o are both 1; a read is accepted where rd_valid_o and rd_ready_i are both 1.
REQ-019 wr_ready_o is 0 exactly when count_o equals capacity; it does not depend combinationally on rd_ready_i.
REQ-020 rd_valid_o is 1 exactly when the head entry is present at rd_data_o; rd_data_o is don't-care while rd_valid_o is 0.
REQ-021 rd_ready_i while rd_valid_o is 0 is legal and has no effect.
REQ-022 Write and read pointers increment on their accepted transfers and wrap from DEPTH-1 to 0.
REQ-023 On a simultaneous accepted write and read, count_o is unchanged and both pointers advance.
REQ-024 count_o, almost_full_o (count >= AF_LEVEL) and almost_empty_o (count <= AE_LEVEL) are registered and updated on the same edge.
REQ-025 overflow_o pulses 1 for one cycle on the edge after wr_valid_i=1 with wr_ready_o=0; the data is discarded.
REQ-026 When flush_i=1, the next edge zeroes pointers and count and drops any output-register entry; flush overrides simultaneous write and read requests, and overflow_o is not raised.
REQ-027 Data order is strictly first-in first-out; an accepted entry is never duplicated or lost except by flush or reset.

Reset
REQ-028 rst_i=1 immediately forces pointers=0, count_o=0, wr_ready_o=1, rd_valid_o=0, almost_full_o=0, almost_empty_o=1, overflow_o=0, output register cleared.
REQ-029 The storage array is not reset; contents are undefined until written.
REQ-030 Reset asserted mid-transfer discards all entries; the first accepted write after release becomes the head.

Configuration
REQ-031 Macro SYNC_FIFO_OUT_REG_EN undefined: rd_data_o is an asynchronous read of array[rd_ptr]; capacity is DEPTH; a write accepted at edge N gives rd_valid_o=1 after edge N.
REQ-032 Macro SYNC_FIFO_OUT_REG_EN defined: rd_data_o comes from a prefetch output register fed from the array; capacity is DEPTH+1 and count_o includes the register entry; the first write to an empty FIFO at edge N gives rd_valid_o=1 after edge N+1; back-to-back reads sustain one entry per cycle with no bubble.

Structure
REQ-033 Package sync_fifo_pkg holds the CNT_W/PTR_W width functions and the reset constants.
REQ-034 Sub-module sync_fifo_ram holds the array, the single write port and the asynchronous read port; sync_fifo holds pointers, count, flags and the optional output register.

Verification
REQ-035 DEPTH=5, no macro: write 5 words 0x11..0x15 -> wr_ready_o=0 after the 5th, count_o=5, almost_full_o=1; read all -> 0x11..0x15 in order, pointers wrap.
REQ-036 Full plus wr_valid_i=1 for 2 cycles -> overflow_o pulses 2 cycles, count_o stays 5, no data corruption.
REQ-037 count_o=3, wr_valid_i=rd_valid_o=rd_ready_i=1 for 10 cycles -> count_o stays 3, output sequence matches the input sequence delayed by 3.
REQ-038 count_o=4, flush_i=1 with simultaneous write -> next cycle count_o=0, rd_valid_o=0, almost_empty_o=1, overflow_o=0.
REQ-039 rst_i pulsed asynchronously mid-stream -> all outputs take REQ-028 values before the next edge; a subsequent write 0xAA is read first.
REQ-040 Macro defined, DEPTH=4: write 5 words -> wr_ready_o=0, count_o=5; first rd_valid_o appears 2 edges after the first write; streamed reads show no bubbles.
